// File: rtl/lcd_pkg.sv
// Shared definitions for the LCD tick-driven sequencer and its tick source.
// Contents: FSM state encoding, HD44780 opcodes, init ROM contents and
// length, and the tick saturation value/width shared with the tick generator.
package lcd_pkg;

  localparam int LCD_TICK_W    = 17;
  localparam int LCD_MAX_TICKS = 96000;
  localparam int INIT_LEN      = 4;

  localparam logic [7:0] LCD_CLEAR     = 8'h01;
  localparam logic [7:0] LCD_HOME      = 8'h02;
  localparam logic [7:0] LCD_ENTRY     = 8'h06;
  localparam logic [7:0] LCD_DISP_ON   = 8'h0C;
  localparam logic [7:0] LCD_FUNC_8B2L = 8'h38;

  typedef enum logic [2:0] {
    ST_POWERUP,
    ST_I_SETUP,
    ST_I_PULSE,
    ST_I_WAIT,
    ST_READY,
    ST_W_SETUP,
    ST_W_PULSE,
    ST_W_WAIT
  } lcd_state_e;

  // Init order: 8-bit/2-line, display on, clear, entry increment.
  function automatic logic [7:0] init_rom(input logic [1:0] idx);
    case (idx)
      2'd0:    return LCD_FUNC_8B2L;
      2'd1:    return LCD_DISP_ON;
      2'd2:    return LCD_CLEAR;
      default: return LCD_ENTRY;
    endcase
  endfunction

endpackage

// File: rtl/lcd_ms_strobe.sv
// Turns the free-running ms tick count into per-cycle events.
// Ports:
//   clk, rst_n  - system clock, synchronous active-low reset
//   ticks       - ms count from the tick generator
//   ms_stb      - one cycle high whenever the count advanced (any jump size)
//   restart     - count went backwards, i.e. the tick source was stopped
//   sat         - count sits at its saturation value
module lcd_ms_strobe #(
  parameter int TICK_W    = 17,
  parameter int MAX_TICKS = 96000
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [TICK_W-1:0] ticks,
  output logic              ms_stb,
  output logic              restart,
  output logic              sat
);

  logic [TICK_W-1:0] ticks_q;

  always_ff @(posedge clk) begin
    if (!rst_n) ticks_q <= '0;
    else        ticks_q <= ticks;
  end

  assign ms_stb  = (ticks > ticks_q);
  assign restart = (ticks < ticks_q);
  assign sat     = (ticks == TICK_W'(MAX_TICKS));

endmodule

// File: rtl/lcd_ticks_sequencer.sv
// HD44780 8-bit interface sequencer timed from the ms tick count.
// Runs power-up wait and the 4-byte init sequence, then accepts writes.
// Ports:
//   clk, rst_n                  - system clock, synchronous active-low reset
//   ticks                       - ms count (returns to 0 when the source stops)
//   cmd_valid/cmd_ready         - upstream write handshake
//   cmd_rs, cmd_data            - register select and byte for the write
//   lcd_rs, lcd_rw, lcd_e,
//   lcd_data                    - LCD pins (lcd_rw is always write)
//   init_done                   - init finished, cleared by restart/reset
//   busy                        - low only while waiting for a write
//
// state      | meaning
// POWERUP    | wait POWERUP_MS strobes after start/restart
// I_SETUP    | init byte on bus, E low (address setup)
// I_PULSE    | E high for E_PULSE_CYC cycles
// I_WAIT     | wait CMD_MS strobes, then next init byte or READY
// READY      | accept a write from upstream
// W_SETUP    | user byte on bus, E low
// W_PULSE    | E high for E_PULSE_CYC cycles
// W_WAIT     | wait CMD_MS strobes, then READY
module lcd_ticks_sequencer
  import lcd_pkg::*;
#(
  parameter int E_PULSE_CYC = 12,
  parameter int POWERUP_MS  = 41,
  parameter int CMD_MS      = 3,
  parameter int MAX_TICKS   = LCD_MAX_TICKS,
  parameter int TICK_W      = LCD_TICK_W
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [TICK_W-1:0] ticks,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic              cmd_rs,
  input  logic [7:0]        cmd_data,
  output logic              lcd_rs,
  output logic              lcd_rw,
  output logic              lcd_e,
  output logic [7:0]        lcd_data,
  output logic              init_done,
  output logic              busy
);

  localparam int WAIT_MAX = (POWERUP_MS > CMD_MS) ? POWERUP_MS : CMD_MS;
  localparam int WAIT_W   = $clog2(WAIT_MAX + 1);
  localparam int PULSE_W  = $clog2(E_PULSE_CYC + 1);

  logic ms_stb, restart, sat;

  lcd_ms_strobe #(
    .TICK_W   (TICK_W),
    .MAX_TICKS(MAX_TICKS)
  ) u_ms_strobe (
    .clk    (clk),
    .rst_n  (rst_n),
    .ticks  (ticks),
    .ms_stb (ms_stb),
    .restart(restart),
    .sat    (sat)
  );

  lcd_state_e         state_q;
  logic [WAIT_W-1:0]  wait_cnt_q;
  logic [PULSE_W-1:0] pulse_cnt_q;
  logic [1:0]         idx_q;
  logic               lcd_rs_q, lcd_e_q, cmd_ready_q, init_done_q, busy_q;
  logic [7:0]         lcd_data_q;

  // A saturated tick source never strobes again, so saturation ends any wait.
  logic pwr_done, cmd_done;
  assign pwr_done = sat || (ms_stb && (wait_cnt_q == WAIT_W'(POWERUP_MS - 1)));
  assign cmd_done = sat || (ms_stb && (wait_cnt_q == WAIT_W'(CMD_MS - 1)));

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= ST_POWERUP;
      wait_cnt_q  <= '0;
      pulse_cnt_q <= '0;
      idx_q       <= '0;
      lcd_rs_q    <= 1'b0;
      lcd_e_q     <= 1'b0;
      lcd_data_q  <= '0;
      cmd_ready_q <= 1'b0;
      init_done_q <= 1'b0;
      busy_q      <= 1'b1;
    end else if (restart) begin
      // Tick source stopped: abandon whatever is in flight, even mid-pulse.
      state_q     <= ST_POWERUP;
      wait_cnt_q  <= '0;
      pulse_cnt_q <= '0;
      idx_q       <= '0;
      lcd_e_q     <= 1'b0;
      cmd_ready_q <= 1'b0;
      init_done_q <= 1'b0;
      busy_q      <= 1'b1;
    end else begin
      case (state_q)
        ST_POWERUP: begin
          if (pwr_done) begin
            wait_cnt_q <= '0;
            lcd_data_q <= init_rom(idx_q);
            lcd_rs_q   <= 1'b0;
            state_q    <= ST_I_SETUP;
          end else if (ms_stb) begin
            wait_cnt_q <= wait_cnt_q + 1'b1;
          end
        end
        ST_I_SETUP, ST_W_SETUP: begin
          lcd_e_q     <= 1'b1;
          pulse_cnt_q <= PULSE_W'(E_PULSE_CYC - 1);
          state_q     <= (state_q == ST_I_SETUP) ? ST_I_PULSE : ST_W_PULSE;
        end
        ST_I_PULSE, ST_W_PULSE: begin
          if (pulse_cnt_q == '0) begin
            lcd_e_q    <= 1'b0;
            wait_cnt_q <= '0;
            state_q    <= (state_q == ST_I_PULSE) ? ST_I_WAIT : ST_W_WAIT;
          end else begin
            pulse_cnt_q <= pulse_cnt_q - 1'b1;
          end
        end
        ST_I_WAIT: begin
          if (cmd_done) begin
            wait_cnt_q <= '0;
            if (idx_q == 2'(INIT_LEN - 1)) begin
              init_done_q <= 1'b1;
              cmd_ready_q <= 1'b1;
              busy_q      <= 1'b0;
              state_q     <= ST_READY;
            end else begin
              idx_q      <= idx_q + 2'd1;
              lcd_data_q <= init_rom(idx_q + 2'd1);
              state_q    <= ST_I_SETUP;
            end
          end else if (ms_stb) begin
            wait_cnt_q <= wait_cnt_q + 1'b1;
          end
        end
        ST_READY: begin
          if (cmd_valid && cmd_ready_q) begin
            lcd_rs_q    <= cmd_rs;
            lcd_data_q  <= cmd_data;
            cmd_ready_q <= 1'b0;
            busy_q      <= 1'b1;
            state_q     <= ST_W_SETUP;
          end
        end
        ST_W_WAIT: begin
          if (cmd_done) begin
            wait_cnt_q  <= '0;
            cmd_ready_q <= 1'b1;
            busy_q      <= 1'b0;
            state_q     <= ST_READY;
          end else if (ms_stb) begin
            wait_cnt_q <= wait_cnt_q + 1'b1;
          end
        end
        default: state_q <= ST_POWERUP;
      endcase
    end
  end

  assign lcd_rs    = lcd_rs_q;
  assign lcd_rw    = 1'b0;
  assign lcd_e     = lcd_e_q;
  assign lcd_data  = lcd_data_q;
  assign cmd_ready = cmd_ready_q;
  assign init_done = init_done_q;
  assign busy      = busy_q;

endmodule

// File: tb/tb_lcd_ticks_sequencer.sv
// Bench for lcd_ticks_sequencer: randomized tick pacing and writes, an
// event-level model of the LCD bus checked every cycle, and literal checks
// on init bytes, pulse widths, restart and saturation behaviour.
module tb_lcd_ticks_sequencer;

  localparam int E_CYC    = 12;
  localparam int PWR_MS   = 41;
  localparam int CMD_WAIT = 3;
  localparam int MAXT     = 96000;

  localparam int P_PWR = 0;
  localparam int P_WR  = 1;
  localparam int P_RDY = 2;

  logic        clk = 1'b0;
  logic        rst_n, cmd_valid, cmd_rs;
  logic [16:0] ticks;
  logic [7:0]  cmd_data;
  logic        cmd_ready, lcd_rs, lcd_rw, lcd_e, init_done, busy;
  logic [7:0]  lcd_data;

  always #5 clk = ~clk;

  lcd_ticks_sequencer dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .ticks    (ticks),
    .cmd_valid(cmd_valid),
    .cmd_ready(cmd_ready),
    .cmd_rs   (cmd_rs),
    .cmd_data (cmd_data),
    .lcd_rs   (lcd_rs),
    .lcd_rw   (lcd_rw),
    .lcd_e    (lcd_e),
    .lcd_data (lcd_data),
    .init_done(init_done),
    .busy     (busy)
  );

  // Inputs as the DUT saw them at the last rising edge.
  logic        cap_rst_n, cap_valid, cap_rs;
  logic [16:0] cap_ticks;
  logic [7:0]  cap_data;
  always @(posedge clk) begin
    cap_rst_n <= rst_n;
    cap_valid <= cmd_valid;
    cap_rs    <= cmd_rs;
    cap_ticks <= ticks;
    cap_data  <= cmd_data;
  end

  int vecs = 0;
  int errs = 0;

  logic [7:0] rom [4] = '{8'h38, 8'h0C, 8'h01, 8'h06};

  // Model: a write is an age since it was latched; age 0 is setup,
  // ages 1..E_CYC have E high, later ages wait for CMD_WAIT strobes.
  bit         m_valid = 1'b0;
  int         m_phase, m_age, m_cnt, m_nw, m_prev;
  bit         m_done, m_rs;
  logic [7:0] m_data;

  // Pulse monitor records.
  logic [7:0] rise_d [$];
  logic       rise_r [$];
  int         rise_t [$];
  int         wid_q  [$];
  logic       pe = 1'b0;
  int         e_w = 0;

  bit t_run = 1'b0;
  int t_cd = 0;
  int t_maxstep = 1;

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    vecs++;
    if (got !== exp) begin
      errs++;
      $display("FAIL %s: got %0h expected %0h", name, got, exp);
    end
  endtask

  task automatic m_begin(input logic [7:0] d, input bit r);
    m_phase = P_WR;
    m_age   = 0;
    m_cnt   = 0;
    m_data  = d;
    m_rs    = r;
  endtask

  task automatic m_finish();
    if (m_nw < 4) begin
      m_nw++;
      if (m_nw == 4) begin
        m_done  = 1'b1;
        m_phase = P_RDY;
      end else begin
        m_begin(rom[m_nw], 1'b0);
      end
    end else begin
      m_phase = P_RDY;
    end
  endtask

  task automatic model_step();
    bit stb, back, sat;
    if (cap_rst_n !== 1'b1) begin
      m_valid = 1'b1;
      m_prev = 0; m_phase = P_PWR; m_age = 0; m_cnt = 0; m_nw = 0;
      m_done = 1'b0; m_rs = 1'b0; m_data = 8'h00;
      return;
    end
    if (!m_valid) return;
    stb  = int'(cap_ticks) > m_prev;
    back = int'(cap_ticks) < m_prev;
    sat  = int'(cap_ticks) == MAXT;
    m_prev = int'(cap_ticks);
    if (back) begin
      m_phase = P_PWR; m_age = 0; m_cnt = 0; m_nw = 0; m_done = 1'b0;
      return;
    end
    case (m_phase)
      P_PWR: begin
        if (stb) m_cnt++;
        if (sat || m_cnt == PWR_MS) m_begin(rom[m_nw], 1'b0);
      end
      P_WR: begin
        if (m_age <= E_CYC) begin
          m_age++;
          if (m_age == E_CYC + 1) m_cnt = 0;
        end else begin
          if (stb) m_cnt++;
          if (sat || m_cnt == CMD_WAIT) m_finish();
        end
      end
      default: begin
        if (cap_valid === 1'b1) m_begin(cap_data, cap_rs);
      end
    endcase
  endtask

  // One clock: model update, full output compare, pulse monitor, tick source.
  task automatic cyc();
    logic [13:0] got, expv;
    bit          me;
    int          nt;
    @(negedge clk);
    model_step();
    if (m_valid) begin
      me   = (m_phase == P_WR) && (m_age >= 1) && (m_age <= E_CYC);
      got  = {lcd_e, lcd_rs, lcd_rw, lcd_data, cmd_ready, init_done, busy};
      expv = {me, m_rs, 1'b0, m_data, m_phase == P_RDY, m_done, m_phase != P_RDY};
      vecs++;
      if (got !== expv) begin
        errs++;
        $display("FAIL cycle t=%0t got e=%b rs=%b rw=%b data=%h rdy=%b done=%b busy=%b expected e=%b rs=%b rw=%b data=%h rdy=%b done=%b busy=%b",
                 $time, got[13], got[12], got[11], got[10:3], got[2], got[1], got[0],
                 expv[13], expv[12], expv[11], expv[10:3], expv[2], expv[1], expv[0]);
      end
    end
    if (lcd_e === 1'b1) begin
      if (!pe) begin
        rise_d.push_back(lcd_data);
        rise_r.push_back(lcd_rs);
        rise_t.push_back(int'(cap_ticks));
        e_w = 0;
      end
      e_w++;
    end else if (pe) begin
      wid_q.push_back(e_w);
    end
    pe = (lcd_e === 1'b1);
    if (t_run) begin
      if (t_cd == 0) begin
        nt = int'(ticks) + int'($urandom_range(1, t_maxstep));
        if (nt > MAXT) nt = MAXT;
        ticks = 17'(nt);
        t_cd = int'($urandom_range(2, 5));
      end else begin
        t_cd--;
      end
    end
  endtask

  function automatic logic sig(input int sel);
    case (sel)
      0:       return lcd_e;
      1:       return cmd_ready;
      default: return init_done;
    endcase
  endfunction

  task automatic wait_sig(input int sel, input logic val, input int budget, input string name);
    int n;
    n = 0;
    while (sig(sel) !== val && n < budget) begin
      cyc();
      n++;
    end
    chk(name, 32'(sig(sel)), 32'(val));
  endtask

  task automatic send(input logic r, input logic [7:0] d, input bit drop);
    int n;
    n = 0;
    cmd_valid = 1'b1;
    cmd_rs    = r;
    cmd_data  = d;
    while (cmd_ready !== 1'b1 && n < 3000) begin
      cyc();
      n++;
    end
    chk("accept wait", 32'(cmd_ready), 32'd1);
    cyc();
    if (drop) begin
      cmd_valid = 1'b0;
      cmd_data  = 8'($urandom);
      cmd_rs    = 1'($urandom);
    end
  endtask

  task automatic chk_rise(input int k, input logic r, input logic [7:0] d, input string name);
    if (k < rise_d.size()) begin
      chk({name, " data"}, 32'(rise_d[k]), 32'(d));
      chk({name, " rs"}, 32'(rise_r[k]), 32'(r));
    end else begin
      chk({name, " pulse count"}, 32'(rise_d.size()), 32'(k + 1));
    end
  endtask

  task automatic chk_reset_outputs(input string name);
    chk({name, " lcd_e"}, 32'(lcd_e), 32'd0);
    chk({name, " lcd_rs"}, 32'(lcd_rs), 32'd0);
    chk({name, " lcd_rw"}, 32'(lcd_rw), 32'd0);
    chk({name, " lcd_data"}, 32'(lcd_data), 32'd0);
    chk({name, " cmd_ready"}, 32'(cmd_ready), 32'd0);
    chk({name, " init_done"}, 32'(init_done), 32'd0);
    chk({name, " busy"}, 32'(busy), 32'd1);
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int nb, n;
    logic [7:0] exp_d [$];
    logic       exp_r [$];
    logic [7:0] d;
    logic       r;
    logic [7:0] b2b [3];

    rst_n = 1'b0; ticks = '0; cmd_valid = 1'b0; cmd_rs = 1'b0; cmd_data = '0;
    repeat (3) cyc();
    chk_reset_outputs("reset");

    // Power-up and init with a 1-ms-per-step ramp.
    rst_n = 1'b1; t_run = 1'b1; t_maxstep = 1; t_cd = 2;
    wait_sig(2, 1'b1, 3000, "init_done rise");
    chk("init pulse count", 32'(rise_d.size()), 32'd4);
    if (rise_t.size() > 0) chk("first E rise tick", 32'(rise_t[0]), 32'd41);
    chk_rise(0, 1'b0, 8'h38, "init0");
    chk_rise(1, 1'b0, 8'h0C, "init1");
    chk_rise(2, 1'b0, 8'h01, "init2");
    chk_rise(3, 1'b0, 8'h06, "init3");
    for (int k = 0; k < 4; k++)
      if (k < wid_q.size()) chk("init E width", 32'(wid_q[k]), 32'd12);
    for (int k = 1; k < 4; k++)
      if (k < rise_t.size()) chk("init spacing", 32'(rise_t[k] - rise_t[k-1] >= CMD_WAIT), 32'd1);

    // Single character write.
    nb = rise_d.size();
    send(1'b1, 8'h41, 1'b1);
    chk("ready drop after accept", 32'(cmd_ready), 32'd0);
    wait_sig(1, 1'b1, 1000, "ready after char");
    chk_rise(nb, 1'b1, 8'h41, "char A");

    // Back-to-back with valid held high.
    b2b = '{8'h48, 8'h49, 8'h21};
    nb = rise_d.size();
    for (int k = 0; k < 3; k++) send(1'b1, b2b[k], k == 2);
    wait_sig(1, 1'b1, 1000, "ready after b2b");
    chk("b2b pulse count", 32'(rise_d.size() - nb), 32'd3);
    for (int k = 0; k < 3; k++) chk_rise(nb + k, 1'b1, b2b[k], "b2b");

    // Random writes with random tick pacing and multi-ms jumps.
    t_maxstep = 2;
    nb = rise_d.size();
    for (int k = 0; k < 15; k++) begin
      repeat ($urandom_range(0, 4)) cyc();
      r = 1'($urandom);
      d = 8'($urandom);
      exp_r.push_back(r);
      exp_d.push_back(d);
      send(r, d, 1'b1);
    end
    wait_sig(1, 1'b1, 1000, "ready after random");
    for (int k = 0; k < 15; k++) chk_rise(nb + k, exp_r[k], exp_d[k], "random");

    // Restart in the middle of a user write pulse.
    t_maxstep = 1;
    send(1'b0, 8'h02, 1'b1);
    wait_sig(0, 1'b1, 100, "user E rise");
    repeat (3) cyc();
    t_run = 1'b0; ticks = '0;
    cyc();
    chk("restart W_PULSE lcd_e", 32'(lcd_e), 32'd0);
    chk("restart init_done", 32'(init_done), 32'd0);
    chk("restart busy", 32'(busy), 32'd1);

    // Restart again in the middle of the second init pulse.
    nb = rise_d.size();
    t_run = 1'b1; t_cd = 2;
    n = 0;
    while (rise_d.size() < nb + 2 && n < 2000) begin cyc(); n++; end
    chk("second init pulse seen", 32'(rise_d.size()), 32'(nb + 2));
    repeat (2) cyc();
    t_run = 1'b0; ticks = '0;
    cyc();
    chk("restart I_PULSE lcd_e", 32'(lcd_e), 32'd0);
    chk("restart I_PULSE init_done", 32'(init_done), 32'd0);
    nb = rise_d.size();
    t_run = 1'b1; t_cd = 2;
    n = 0;
    while (rise_d.size() <= nb && n < 2000) begin cyc(); n++; end
    if (rise_t.size() > nb) chk("full power-up after restart", 32'(rise_t[nb]), 32'd41);
    chk_rise(nb, 1'b0, 8'h38, "re-init0");
    wait_sig(2, 1'b1, 2000, "init_done after restart");

    // Saturation during the post-write wait.
    send(1'b0, 8'h0C, 1'b1);
    wait_sig(0, 1'b1, 100, "sat E rise");
    wait_sig(0, 1'b0, 100, "sat E fall");
    t_run = 1'b0; ticks = 17'(MAXT);
    n = 0;
    while (cmd_ready !== 1'b1 && n < 10) begin cyc(); n++; end
    chk("sat wait within 2 cycles", 32'(n >= 1 && n <= 2), 32'd1);
    nb = rise_d.size();
    send(1'b1, 8'h5A, 1'b1);
    wait_sig(1, 1'b1, 100, "ready while saturated");
    chk_rise(nb, 1'b1, 8'h5A, "sat char");

    // Synchronous reset while READY with a write pending.
    cmd_valid = 1'b1; cmd_rs = 1'b1; cmd_data = 8'h77; rst_n = 1'b0;
    cyc();
    chk_reset_outputs("reset in READY");
    rst_n = 1'b1; ticks = '0; cmd_valid = 1'b0;
    nb = rise_d.size();
    repeat (30) cyc();
    chk("no pulse after reset", 32'(rise_d.size()), 32'(nb));

    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end

endmodule
